// File: rtl/tcdm_responder.sv
`default_nettype none
// ============================================================================
// Module      : tcdm_responder
// Description : Target-side responder. Registers single-word requests into a
//               one-entry stage, issues them to one of BankingFactor TCDM
//               banks and returns in-order responses (vld/rdata/err).
// Revision    : 1.0 - initial release
// ============================================================================
module tcdm_responder #(
    parameter int unsigned BankingFactor = 16,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned TCDMAddrWidth = 14,
    parameter logic [DataWidth-1:0] ErrData = 32'hBADCAB1E,
    localparam int unsigned BeWidth      = DataWidth / 8
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   core_data_req_i,
    input  logic [AddrWidth-1:0]                   core_data_addr_i,
    input  logic                                   core_data_wen_i,
    input  logic [DataWidth-1:0]                   core_data_wdata_i,
    input  logic [BeWidth-1:0]                     core_data_be_i,
    output logic                                   core_data_gnt_o,
    output logic                                   core_data_vld_o,
    output logic [DataWidth-1:0]                   core_data_rdata_o,
    output logic                                   core_data_err_o,
    output logic [BankingFactor-1:0]               mem_req_o,
    input  logic [BankingFactor-1:0]               mem_gnt_i,
    output logic [BankingFactor*TCDMAddrWidth-1:0] mem_addr_o,
    output logic [BankingFactor-1:0]               mem_wen_o,
    output logic [BankingFactor*DataWidth-1:0]     mem_wdata_o,
    output logic [BankingFactor*BeWidth-1:0]       mem_be_o,
    input  logic [BankingFactor*DataWidth-1:0]     mem_rdata_i,
    output logic                                   busy_o
);

    localparam int unsigned BANK_SEL  = $clog2(BankingFactor);
    localparam int unsigned ROW_W     = TCDMAddrWidth - 2;
    localparam int unsigned ROW_LSB   = 2 + BANK_SEL;
    localparam int unsigned RANGE_LSB = ROW_LSB + ROW_W;

    // Request decode
    logic [BANK_SEL-1:0] w_req_bank;
    logic [ROW_W-1:0]    w_req_row;
    logic                w_req_err;
    logic                w_unused_addr;

    assign w_req_bank    = core_data_addr_i[2 +: BANK_SEL];
    assign w_req_row     = core_data_addr_i[ROW_LSB +: ROW_W];
    assign w_unused_addr = ^core_data_addr_i[1:0];

    if (AddrWidth > RANGE_LSB) begin : g_range_chk
        assign w_req_err = |core_data_addr_i[AddrWidth-1:RANGE_LSB];
    end else begin : g_range_none
        assign w_req_err = 1'b0;
    end

    // Request stage
    logic                 r_stage_valid;
    logic [BANK_SEL-1:0]  r_stage_bank;
    logic [ROW_W-1:0]     r_stage_row;
    logic                 r_stage_wen;
    logic [DataWidth-1:0] r_stage_wdata;
    logic [BeWidth-1:0]   r_stage_be;
    logic                 r_stage_err;

    // Response register
    logic                 r_resp_valid;
    logic [BANK_SEL-1:0]  r_resp_bank;
    logic                 r_resp_wen;
    logic                 r_resp_err;

    logic [1:0]           r_count;

    logic w_issue_en;
    logic w_stage_issue;
    logic w_resp_blocked;
    logic w_gnt;

    // Kept as a hook: a single stage bounds outstanding requests to two.
    assign w_resp_blocked = 1'b0;

    assign w_issue_en    = r_stage_valid && !r_stage_err;
    assign w_stage_issue = r_stage_valid && (r_stage_err || mem_gnt_i[r_stage_bank]);
    assign w_gnt         = rst_ni && core_data_req_i
                           && (!r_stage_valid || w_stage_issue) && !w_resp_blocked;

    assign core_data_gnt_o = w_gnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stage_valid <= 1'b0;
            r_stage_bank  <= '0;
            r_stage_row   <= '0;
            r_stage_wen   <= 1'b0;
            r_stage_wdata <= '0;
            r_stage_be    <= '0;
            r_stage_err   <= 1'b0;
        end else if (w_gnt) begin
            r_stage_valid <= 1'b1;
            r_stage_bank  <= w_req_bank;
            r_stage_row   <= w_req_row;
            r_stage_wen   <= core_data_wen_i;
            r_stage_wdata <= core_data_wdata_i;
            r_stage_be    <= core_data_be_i;
            r_stage_err   <= w_req_err;
        end else if (w_stage_issue) begin
            r_stage_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_resp_valid <= 1'b0;
            r_resp_bank  <= '0;
            r_resp_wen   <= 1'b0;
            r_resp_err   <= 1'b0;
        end else begin
            r_resp_valid <= w_stage_issue;
            if (w_stage_issue) begin
                r_resp_bank <= r_stage_bank;
                r_resp_wen  <= r_stage_wen;
                r_resp_err  <= r_stage_err;
            end
        end
    end

    // Bank fan-out; unselected banks see all-zero ports
    logic [DataWidth-1:0] w_rdata_bank [BankingFactor];

    for (genvar b = 0; b < BankingFactor; b++) begin : g_bank
        localparam logic [BANK_SEL-1:0] BANK_IDX = BANK_SEL'(b);
        logic w_sel;
        assign w_sel           = w_issue_en && (r_stage_bank == BANK_IDX);
        assign mem_req_o[b]    = w_sel;
        assign mem_wen_o[b]    = w_sel && r_stage_wen;
        assign mem_addr_o[b*TCDMAddrWidth +: TCDMAddrWidth] = w_sel ? {r_stage_row, 2'b00} : '0;
        assign mem_wdata_o[b*DataWidth +: DataWidth]        = w_sel ? r_stage_wdata : '0;
        assign mem_be_o[b*BeWidth +: BeWidth]               = w_sel ? r_stage_be : '0;
        assign w_rdata_bank[b] = mem_rdata_i[b*DataWidth +: DataWidth];
    end

    always_comb begin
        core_data_rdata_o = '0;
        core_data_err_o   = 1'b0;
        if (r_resp_valid) begin
            if (r_resp_err) begin
                core_data_rdata_o = ErrData;
                core_data_err_o   = 1'b1;
            end else if (!r_resp_wen) begin
                core_data_rdata_o = w_rdata_bank[r_resp_bank];
            end
        end
    end

    assign core_data_vld_o = r_resp_valid;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count <= 2'd0;
        end else begin
            case ({w_gnt, r_resp_valid})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign busy_o = (r_count != 2'd0);

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (rst_ni) begin
            a_count_max : assert (r_count <= 2'd2);
            a_req_onehot : assert ($onehot0(mem_req_o));
        end
    end
`endif

endmodule
`default_nettype wire
